// File: rtl/channel_mux_if.sv
// ---------------------------------------------------------------------------
// channel_mux_if
//  Bundles the per-channel packet-read handshake and the serialised USB write
//  stream of channel_mux.
//  NUM_CHAN must match the NUM_CHAN of the channel_mux instance bound to it.
//  Signals:
//   have_pkt_channel [NUM_CHAN:0]       per-channel complete packet available
//   chan_data        [32*(NUM_CHAN+1)]  per-channel read data, ch i at [32*i +: 32]
//   have_space                          downstream can take one 128-word packet
//   RD_channel       [NUM_CHAN:0]       read strobe to the granted channel
//   RD_done_channel  [NUM_CHAN:0]       packet fully read pulse
//   usbdata_out      [31:0]             serialised output word
//   WR_out                              usbdata_out valid strobe
//  Modports: master = the multiplexer, slave = channels plus packet writer.
// ---------------------------------------------------------------------------
interface channel_mux_if #(
  parameter int NUM_CHAN = 2
);
  logic [NUM_CHAN:0]            have_pkt_channel;
  logic [32*(NUM_CHAN+1)-1:0]   chan_data;
  logic                         have_space;
  logic [NUM_CHAN:0]            RD_channel;
  logic [NUM_CHAN:0]            RD_done_channel;
  logic [31:0]                  usbdata_out;
  logic                         WR_out;

  modport master (
    input  have_pkt_channel, chan_data, have_space,
    output RD_channel, RD_done_channel, usbdata_out, WR_out
  );

  modport slave (
    output have_pkt_channel, chan_data, have_space,
    input  RD_channel, RD_done_channel, usbdata_out, WR_out
  );
endinterface

// File: rtl/channel_mux.sv
// ---------------------------------------------------------------------------
// channel_mux
//  RX-side packet multiplexer. Round-robin arbitrates over NUM_CHAN data
//  channels plus one control channel (index NUM_CHAN), reads one complete
//  128-word packet from the granted channel and serialises it as 32-bit words
//  (one word every two cycles). Word 0 gets its header channel field [20:16]
//  rewritten to the granted channel number (5'h1f for the control channel).
//  Ports:
//   rxclk  in  sole clock, rising edge
//   reset  in  asynchronous active-high reset, clears all state
//   bus    master modport of channel_mux_if (handshake and output stream)
// ---------------------------------------------------------------------------
module channel_mux #(
  parameter int NUM_CHAN = 2
) (
  input  logic          rxclk,
  input  logic          reset,
  channel_mux_if.master bus
);
  localparam int NCH  = NUM_CHAN + 1;
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    READ       = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t            state_r, next_state_s;
  logic [SELW-1:0]   sel_r, sel_s;
  logic [SELW-1:0]   last_r, last_s;
  logic [6:0]        count_r, count_s;
  logic [NCH-1:0]    rd_channel_r, rd_channel_s;
  logic [NCH-1:0]    rd_done_r, rd_done_s;
  logic [31:0]       usbdata_r, usbdata_s;
  logic              wr_r, wr_s;
  logic [31:0]       chan_word_s [NCH];
  logic [4:0]        hdr_chan_s;
  logic              start_s;

  // First requesting channel after 'last', wrapping through NUM_CHAN to 0.
  function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [SELW-1:0] last);
    logic [SELW-1:0] pick;
    logic            found;
    int              idx;
    pick  = {SELW{1'b0}};
    found = 1'b0;
    for (int off = 1; off <= NCH; off++) begin
      idx = (int'(last) + off) % NCH;
      if (!found && req[idx]) begin
        pick  = SELW'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign chan_word_s[g] = bus.chan_data[32*g +: 32];
  end

  // Control channel is tagged 5'h1f, data channels carry their own index.
  assign hdr_chan_s = (int'(sel_r) == NUM_CHAN) ? 5'h1f : 5'(sel_r);

  // A new grant is only taken once the previous RD_done pulse has cleared,
  // giving the finished channel one cycle to drop its have_pkt flag.
  assign start_s = (rd_done_r == {NCH{1'b0}}) && (|bus.have_pkt_channel);

  // State register.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) next_state_s = WAIT_SPACE;
        else         next_state_s = IDLE;
      end
      WAIT_SPACE: begin
        if (bus.have_space) next_state_s = READ;
        else                next_state_s = WAIT_SPACE;
      end
      READ:    next_state_s = CAPTURE;
      CAPTURE: begin
        if (count_r == 7'd127) next_state_s = DONE;
        else                   next_state_s = READ;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output and datapath next values; strobes default low each cycle.
  always_comb begin
    sel_s        = sel_r;
    last_s       = last_r;
    count_s      = count_r;
    rd_channel_s = {NCH{1'b0}};
    rd_done_s    = {NCH{1'b0}};
    usbdata_s    = usbdata_r;
    wr_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) sel_s = rr_pick(bus.have_pkt_channel, last_r);
        else         sel_s = sel_r;
      end
      WAIT_SPACE: begin
        if (bus.have_space) rd_channel_s[sel_r] = 1'b1;
        else                rd_channel_s = {NCH{1'b0}};
      end
      READ: begin
        wr_s = 1'b0;
      end
      CAPTURE: begin
        usbdata_s = chan_word_s[sel_r];
        if (count_r == 7'd0) usbdata_s[20:16] = hdr_chan_s;
        else                 usbdata_s[20:16] = chan_word_s[sel_r][20:16];
        wr_s    = 1'b1;
        count_s = count_r + 7'd1;
        if (count_r != 7'd127) rd_channel_s[sel_r] = 1'b1;
        else                   rd_channel_s = {NCH{1'b0}};
      end
      DONE: begin
        rd_done_s[sel_r] = 1'b1;
        last_s           = sel_r;
        count_s          = 7'd0;
      end
      default: begin
        wr_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered output stage.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      sel_r        <= {SELW{1'b0}};
      last_r       <= SELW'(NUM_CHAN);
      count_r      <= 7'd0;
      rd_channel_r <= {NCH{1'b0}};
      rd_done_r    <= {NCH{1'b0}};
      usbdata_r    <= 32'd0;
      wr_r         <= 1'b0;
    end else begin
      sel_r        <= sel_s;
      last_r       <= last_s;
      count_r      <= count_s;
      rd_channel_r <= rd_channel_s;
      rd_done_r    <= rd_done_s;
      usbdata_r    <= usbdata_s;
      wr_r         <= wr_s;
    end
  end

  assign bus.RD_channel      = rd_channel_r;
  assign bus.RD_done_channel = rd_done_r;
  assign bus.usbdata_out     = usbdata_r;
  assign bus.WR_out          = wr_r;
endmodule

// File: tb/tb_channel_mux.sv
// ---------------------------------------------------------------------------
// tb_channel_mux
//  Directed bench for channel_mux (NUM_CHAN = 2). Each channel is modelled as
//  a 128-word packet store returning a word one cycle after its read strobe;
//  have_pkt follows a count of packets offered minus packets completed.
//  Channel c word k is (c << 24) + k, except word 0 which holds a header
//  chosen per test vector.
// ---------------------------------------------------------------------------
module tb_channel_mux;
  localparam int NUM_CHAN = 2;
  localparam int NCH      = NUM_CHAN + 1;

  logic rxclk = 1'b0;
  logic reset;
  always #5 rxclk = ~rxclk;

  channel_mux_if #(.NUM_CHAN(NUM_CHAN)) bus ();
  channel_mux #(.NUM_CHAN(NUM_CHAN)) dut (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [NCH][128];
  int          add_total  [NCH] = '{0, 0, 0};
  int          done_total [NCH] = '{0, 0, 0};
  logic [6:0]  ptr [NCH];
  logic [31:0] cd  [NCH];

  // Channel read model; reset restarts each store at word 0.
  always @(posedge rxclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) ptr[i] <= 7'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.RD_channel[i]) begin
          cd[i]  <= mem[i][ptr[i]];
          ptr[i] <= ptr[i] + 7'd1;
        end
      end
    end
  end

  // Completed packets retire from the channel's pending count.
  always @(posedge rxclk) begin
    for (int i = 0; i < NCH; i++)
      if (bus.RD_done_channel[i]) done_total[i] <= done_total[i] + 1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign bus.have_pkt_channel[g]  = (add_total[g] > done_total[g]);
    assign bus.chan_data[32*g +: 32] = cd[g];
  end

  typedef struct {
    int          a0, a1, a2;   // packets added to ch0/ch1/ch2 before this record
    logic [31:0] hdr;          // header word 0 written into the expected channel
    int          exp_ch;
    logic [31:0] exp_word0;
    logic [2:0]  exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Collect one packet from the expected channel and verify it end to end.
  task automatic collect(input string name, input int exp_ch,
                         input logic [31:0] exp_word0, input logic [2:0] exp_done);
    int          k, cyc, last_wr, gap_bad, body_bad, rd_bad, early_done;
    logic [2:0]  mask, done_seen;
    logic [31:0] exp;
    k = 0; cyc = 0; last_wr = 0; gap_bad = 0; body_bad = 0; rd_bad = 0; early_done = 0;
    mask = 3'b001 << exp_ch;
    while (k < 128 && cyc < 1000) begin
      @(negedge rxclk);
      cyc++;
      if ((bus.RD_channel & ~mask) != 3'b000) rd_bad++;
      if (bus.RD_done_channel != 3'b000) early_done++;
      if (bus.WR_out) begin
        if (k == 0) begin
          check({name, " word0"}, bus.usbdata_out, exp_word0);
        end else begin
          if (cyc - last_wr != 2) gap_bad++;
          exp = (32'(exp_ch) << 24) + 32'(k);
          if (bus.usbdata_out !== exp) begin
            if (body_bad == 0)
              $display("FAIL %s body word %0d: got %h expected %h", name, k, bus.usbdata_out, exp);
            body_bad++;
          end
        end
        last_wr = cyc;
        k++;
      end
    end
    check({name, " wr count"}, 32'(k), 32'd128);
    check({name, " wr gaps"}, 32'(gap_bad), 32'd0);
    check({name, " body errors"}, 32'(body_bad), 32'd0);
    check({name, " stray rd"}, 32'(rd_bad), 32'd0);
    check({name, " early done"}, 32'(early_done), 32'd0);
    done_seen = 3'b000;
    for (int i = 0; i < 4 && done_seen == 3'b000; i++) begin
      @(negedge rxclk);
      done_seen = bus.RD_done_channel;
    end
    check({name, " rd_done"}, {29'd0, done_seen}, {29'd0, exp_done});
  endtask

  initial begin
    int k, cyc, rd_bad;

    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < 128; w++)
        mem[c][w] = (32'(c) << 24) + 32'(w);

    // Header rewrite and arbitration vectors; pointer state carries over.
    vecs[0] = '{1, 0, 0, 32'h0007_0000, 0, 32'h0000_0000, 3'b001};
    vecs[1] = '{0, 0, 1, 32'h0000_0000, 2, 32'h001F_0000, 3'b100};
    vecs[2] = '{0, 1, 0, 32'hFFFF_FFFF, 1, 32'hFFE1_FFFF, 3'b010};
    vecs[3] = '{0, 0, 1, 32'h1234_5678, 2, 32'h123F_5678, 3'b100};
    vecs[4] = '{2, 1, 1, 32'h0000_0000, 0, 32'h0000_0000, 3'b001};
    vecs[5] = '{0, 0, 0, 32'hABCD_0123, 1, 32'hABC1_0123, 3'b010};
    vecs[6] = '{0, 0, 0, 32'h0000_0000, 2, 32'h001F_0000, 3'b100};
    vecs[7] = '{0, 0, 0, 32'h001F_FFFF, 0, 32'h0000_FFFF, 3'b001};

    bus.have_space = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge rxclk);
    check("reset RD_channel", {29'd0, bus.RD_channel}, 32'd0);
    check("reset RD_done", {29'd0, bus.RD_done_channel}, 32'd0);
    check("reset usbdata", bus.usbdata_out, 32'd0);
    check("reset WR", {31'd0, bus.WR_out}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      add_total[0] += vecs[v].a0;
      add_total[1] += vecs[v].a1;
      add_total[2] += vecs[v].a2;
      mem[vecs[v].exp_ch][0] = vecs[v].hdr;
      collect($sformatf("vec%0d", v), vecs[v].exp_ch, vecs[v].exp_word0, vecs[v].exp_done);
    end

    // Reset in the middle of a ch1 packet with ch1 and ch2 pending.
    add_total[1] += 1;
    add_total[2] += 1;
    k = 0; cyc = 0;
    while (k < 60 && cyc < 1000) begin
      @(negedge rxclk);
      cyc++;
      if (bus.WR_out) k++;
    end
    check("abort words before reset", 32'(k), 32'd60);
    reset = 1'b1;
    #1;
    check("async RD_channel", {29'd0, bus.RD_channel}, 32'd0);
    check("async RD_done", {29'd0, bus.RD_done_channel}, 32'd0);
    check("async usbdata", bus.usbdata_out, 32'd0);
    check("async WR", {31'd0, bus.WR_out}, 32'd0);
    repeat (2) @(negedge rxclk);
    reset = 1'b0;
    collect("after reset ch1", 1, 32'hABC1_0123, 3'b010);
    collect("after reset ch2", 2, 32'h001F_0000, 3'b100);

    // Grant held off while downstream has no space.
    bus.have_space = 1'b0;
    add_total[1] += 1;
    rd_bad = 0;
    repeat (20) begin
      @(negedge rxclk);
      if (bus.RD_channel != 3'b000) rd_bad++;
    end
    check("no space RD held", 32'(rd_bad), 32'd0);
    bus.have_space = 1'b1;
    @(negedge rxclk);
    check("space RD_channel", {29'd0, bus.RD_channel}, 32'h0000_0002);
    collect("space ch1", 1, 32'hABC1_0123, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
